// File: rtl/minority_pkg.sv
`default_nettype none
// ============================================================================
// minority_pkg : shared constants, FSM encodings and golden minority model
// Revision     : 1.0
// ============================================================================
package minority_pkg;

    localparam int NUM_VECTORS = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_APPLY  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_FIN    = 3'd4;

    // Vector bit 3 drives A, bit 0 drives D; only the population count matters.
    function automatic logic minority_golden(input logic [3:0] vec, input logic tie_value);
        logic [2:0] ones;
        ones = {2'b00, vec[3]} + {2'b00, vec[2]} + {2'b00, vec[1]} + {2'b00, vec[0]};
        if (ones < 3'd2) begin
            return 1'b1;
        end else if (ones == 3'd2) begin
            return tie_value;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/minority_bist_top.sv
`default_nettype none
// ============================================================================
// minority_bist_top : self-test harness pairing the BIST sequencer with the
//                     minority unit it exercises
// Revision          : 1.0
// ============================================================================
module minority_bist_top #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          TIE_VALUE     = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  fail_cnt,
    output logic [3:0]  first_fail,
    output logic [15:0] signature
);

    logic unit_a;
    logic unit_b;
    logic unit_c;
    logic unit_d;
    logic unit_z;

    minority_unit #(
        .TIE_VALUE (TIE_VALUE)
    ) u_unit (
        .a (unit_a),
        .b (unit_b),
        .c (unit_c),
        .d (unit_d),
        .z (unit_z)
    );

    minority_bist_ctrl #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .TIE_VALUE     (TIE_VALUE)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .z          (unit_z),
        .a          (unit_a),
        .b          (unit_b),
        .c          (unit_c),
        .d          (unit_d),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_cnt   (fail_cnt),
        .first_fail (first_fail),
        .signature  (signature)
    );

endmodule
`default_nettype wire

// File: rtl/minority_unit.sv
`default_nettype none
// ============================================================================
// minority_unit : combinational 4-input minority gate with configurable tie
// Revision      : 1.0
// ============================================================================
module minority_unit #(
    parameter bit TIE_VALUE = 1'b0
) (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic z
);

    logic [2:0] ones;

    always_comb begin
        ones = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        z    = (ones < 3'd2) | ((ones == 3'd2) & TIE_VALUE);
    end

endmodule
`default_nettype wire

// File: rtl/minority_bist_ctrl.sv
`default_nettype none
// ============================================================================
// minority_bist_ctrl : walks all 16 vectors through the minority unit, checks
//                      Z against the golden model and accumulates results
// Revision           : 1.0
// ============================================================================
module minority_bist_ctrl
    import minority_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          TIE_VALUE     = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        z,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  fail_cnt,
    output logic [3:0]  first_fail,
    output logic [15:0] signature
);

    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [3:0] LAST_VEC    = 4'(NUM_VECTORS - 1);

    logic [2:0] state;
    logic [3:0] vec;
    logic [3:0] settle_cnt;
    logic [3:0] drive;
    logic       expected;
    logic       mismatch;

    always_comb begin
        expected = minority_golden(vec, TIE_VALUE);
        mismatch = (z != expected);
    end

    // Unit inputs come from a dedicated register so they return to zero
    // outside a run while vec keeps its last value.
    assign {a, b, c, d} = drive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vec        <= 4'd0;
            settle_cnt <= 4'd0;
            drive      <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_cnt   <= 5'd0;
            first_fail <= 4'd0;
            signature  <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    drive <= 4'd0;
                    if (start && !abort) begin
                        state      <= ST_APPLY;
                        vec        <= 4'd0;
                        settle_cnt <= 4'd0;
                        busy       <= 1'b1;
                        fail_cnt   <= 5'd0;
                        first_fail <= 4'd0;
                        signature  <= 16'd0;
                        pass       <= 1'b0;
                    end
                end

                ST_APPLY: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        drive <= 4'd0;
                    end else if (SETTLE_CYCLES > 0) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= 4'd0;
                    end else begin
                        state <= ST_SAMPLE;
                    end
                end

                ST_SETTLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        drive <= 4'd0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                ST_SAMPLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        drive <= 4'd0;
                    end else begin
                        signature[vec] <= z;
                        if (mismatch) begin
                            fail_cnt <= fail_cnt + 5'd1;
                            if (fail_cnt == 5'd0) begin
                                first_fail <= vec;
                            end
                        end
                        if (vec == LAST_VEC) begin
                            state <= ST_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            drive <= 4'd0;
                            pass  <= (fail_cnt == 5'd0) && !mismatch;
                        end else begin
                            state <= ST_APPLY;
                            vec   <= vec + 4'd1;
                            drive <= vec + 4'd1;
                        end
                    end
                end

                ST_FIN: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    drive <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_minority_bist_ctrl.sv
`default_nettype none
// ============================================================================
// tb_minority_bist_ctrl : directed checks of the BIST sequencer against
//                         hand-computed results, default and tie-high builds
// Revision              : 1.0
// ============================================================================
module tb_minority_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    int          mode;

    logic        z1, a1, b1, c1, d1, busy1, done1, pass1;
    logic [4:0]  fail_cnt1;
    logic [3:0]  first_fail1;
    logic [15:0] sig1;

    logic        z2, a2, b2, c2, d2, busy2, done2, pass2;
    logic [4:0]  fail_cnt2;
    logic [3:0]  first_fail2;
    logic [15:0] sig2;

    int compared = 0;
    int failed   = 0;

    always #5 clk = ~clk;

    // Unit models: mode 0 healthy (tie low), 1 stuck at 0, 2 stuck at 1.
    always_comb begin
        int n1;
        int n2;
        n1 = int'(a1) + int'(b1) + int'(c1) + int'(d1);
        n2 = int'(a2) + int'(b2) + int'(c2) + int'(d2);
        if (mode == 1)      z1 = 1'b0;
        else if (mode == 2) z1 = 1'b1;
        else                z1 = (n1 <= 1);
        z2 = (n2 <= 2);
    end

    minority_bist_ctrl #(
        .SETTLE_CYCLES (1),
        .TIE_VALUE     (1'b0)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .abort (abort), .z (z1),
        .a (a1), .b (b1), .c (c1), .d (d1),
        .busy (busy1), .done (done1), .pass (pass1),
        .fail_cnt (fail_cnt1), .first_fail (first_fail1), .signature (sig1)
    );

    minority_bist_ctrl #(
        .SETTLE_CYCLES (0),
        .TIE_VALUE     (1'b1)
    ) dut_tie (
        .clk (clk), .rst_n (rst_n), .start (start), .abort (abort), .z (z2),
        .a (a2), .b (b2), .c (c2), .d (d2),
        .busy (busy2), .done (done2), .pass (pass2),
        .fail_cnt (fail_cnt2), .first_fail (first_fail2), .signature (sig2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_to_done(input string tag, input int exp_edges);
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done1 && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(exp_edges));
    endtask

    initial begin
        bit seen_done;
        int n;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode  = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy1), 32'd0);
        check("rst_done",  32'(done1), 32'd0);
        check("rst_pass",  32'(pass1), 32'd0);
        check("rst_fcnt",  32'(fail_cnt1), 32'd0);
        check("rst_first", 32'(first_fail1), 32'd0);
        check("rst_sig",   32'(sig1), 32'd0);
        check("rst_abcd",  32'({a1, b1, c1, d1}), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);

        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy1), 32'd0);

        // Healthy run; a stray START mid-run must change nothing.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 48; k++) begin
            if (k == 10) start = 1'b1;
            if (k == 11) start = 1'b0;
            check("t1_abcd",  32'({a1, b1, c1, d1}), 32'(k / 3));
            check("t1_busy",  32'(busy1), 32'd1);
            check("t1_done",  32'(done1), 32'd0);
            check("t4_done2", 32'(done2), 32'(k == 32));
            check("t4_busy2", 32'(busy2), 32'(k < 32));
            tick();
        end
        check("t1_done_end", 32'(done1), 32'd1);
        check("t1_busy_end", 32'(busy1), 32'd0);
        check("t1_abcd_end", 32'({a1, b1, c1, d1}), 32'd0);
        check("t1_pass",     32'(pass1), 32'd1);
        check("t1_fcnt",     32'(fail_cnt1), 32'd0);
        check("t1_sig",      32'(sig1), 32'h0117);
        check("t4_pass2",    32'(pass2), 32'd1);
        check("t4_fcnt2",    32'(fail_cnt2), 32'd0);
        check("t4_sig2",     32'(sig2), 32'h177F);
        tick();
        check("t1_done_pulse", 32'(done1), 32'd0);
        check("t1_pass_hold",  32'(pass1), 32'd1);

        mode = 1;
        run_to_done("t2_edges", 48);
        check("t2_fcnt",  32'(fail_cnt1), 32'd5);
        check("t2_first", 32'(first_fail1), 32'd0);
        check("t2_sig",   32'(sig1), 32'h0000);
        check("t2_pass",  32'(pass1), 32'd0);
        tick();

        mode = 2;
        run_to_done("t3_edges", 48);
        check("t3_fcnt",  32'(fail_cnt1), 32'd11);
        check("t3_first", 32'(first_fail1), 32'd3);
        check("t3_sig",   32'(sig1), 32'hFFFF);
        check("t3_pass",  32'(pass1), 32'd0);
        tick();

        // Abort in the 20th busy cycle (SETTLE of vector 6); vectors 0..5 sampled.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        check("t5_busy_pre", 32'(busy1), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy",  32'(busy1), 32'd0);
        check("t5_done",  32'(done1), 32'd0);
        check("t5_abcd",  32'({a1, b1, c1, d1}), 32'd0);
        check("t5_pass",  32'(pass1), 32'd0);
        check("t5_fcnt",  32'(fail_cnt1), 32'd2);
        check("t5_first", 32'(first_fail1), 32'd3);
        check("t5_sig",   32'(sig1), 32'h003F);
        seen_done = 1'b0;
        repeat (60) begin
            tick();
            if (done1) seen_done = 1'b1;
        end
        check("t5_no_done", 32'(seen_done), 32'd0);
        check("t5_idle",    32'(busy1), 32'd0);

        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_re_busy",  32'(busy1), 32'd1);
        check("t5_re_abcd",  32'({a1, b1, c1, d1}), 32'd0);
        check("t5_re_fcnt",  32'(fail_cnt1), 32'd0);
        check("t5_re_first", 32'(first_fail1), 32'd0);
        check("t5_re_sig",   32'(sig1), 32'd0);
        n = 0;
        while (!done1 && n < 300) begin
            tick();
            n++;
        end
        check("t5_re_edges", 32'(n), 32'd48);
        check("t5_re_pass",  32'(pass1), 32'd1);
        check("t5_re_sig2",  32'(sig1), 32'h0117);
        tick();

        // Asynchronous reset mid-run, asserted between clock edges.
        mode  = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("t6_busy_pre", 32'(busy1), 32'd1);
        check("t6_sig_pre",  32'(sig1), 32'h0007);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy1), 32'd0);
        check("t6_abcd", 32'({a1, b1, c1, d1}), 32'd0);
        check("t6_sig",  32'(sig1), 32'd0);
        check("t6_pass", 32'(pass1), 32'd0);
        check("t6_done", 32'(done1), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        start = 1'b1;
        abort = 1'b1;
        tick();
        check("t7_busy", 32'(busy1), 32'd0);
        tick();
        check("t7_busy_b", 32'(busy1), 32'd0);
        check("t7_abcd",   32'({a1, b1, c1, d1}), 32'd0);
        start = 1'b0;
        abort = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/minority_bist_ctrl.md
Name: minority_bist_ctrl

Overview:
Built-in self-test sequencer for the 4-input minority unit. On START it walks all 16 input vectors through the unit, waits a programmable settle time, samples Z, and compares it against a golden minority function. It accumulates a response signature, a mismatch count, the first failing vector index and a pass flag. It sits beside the minority instance in the self-test harness and owns that instance's A/B/C/D inputs while BUSY.

Parameters:
SETTLE_CYCLES, 1, wait cycles between APPLY and SAMPLE (0..15; 0 means sample in the cycle right after APPLY)
TIE_VALUE, 0, expected Z when exactly two inputs are 1

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  asynchronous active-low reset
START  in  1  begin a run; sampled only in IDLE
ABORT  in  1  abandon the run in progress
Z  in  1  minority unit output
A  out  1  minority unit input (vector bit 3)
B  out  1  minority unit input (vector bit 2)
C  out  1  minority unit input (vector bit 1)
D  out  1  minority unit input (vector bit 0)
BUSY  out  1  high in APPLY, SETTLE and SAMPLE
DONE  out  1  one-cycle completion pulse
PASS  out  1  all 16 vectors matched; valid from DONE until the next START
FAIL_CNT  out  5  mismatch count, 0..16
FIRST_FAIL  out  4  index of the first mismatching vector; meaningful only when FAIL_CNT != 0
SIGNATURE  out  16  bit i = sampled Z for vector i

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; all outputs 0; vector counter 0; settle counter 0.
- Golden value: expected = 1 if popcount{A,B,C,D} < 2; TIE_VALUE if popcount == 2; otherwise 0.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, FIN.
- IDLE: A..D = 0.
  - START=1 and ABORT=0 → APPLY with vec=0.
  - On that same edge, FAIL_CNT, FIRST_FAIL, SIGNATURE and PASS clear to 0.
- APPLY: registered {A,B,C,D} = vec for the whole vector period (APPLY through SAMPLE).
  - Next state is SETTLE if SETTLE_CYCLES > 0, else SAMPLE.
- SETTLE: stays exactly SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE: Z is compared at the closing edge.
  - SIGNATURE[vec] <= Z.
  - On mismatch, FAIL_CNT increments; if FAIL_CNT was 0, FIRST_FAIL <= vec.
  - If vec == 15 → FIN; else vec <= vec+1 → APPLY. The counter does not wrap past 15.
- FIN: one cycle. DONE=1, BUSY=0, PASS = (FAIL_CNT == 0), A..D = 0, then IDLE.
- Timing:
  - Each vector takes 2+SETTLE_CYCLES cycles.
  - BUSY is high for 16*(2+SETTLE_CYCLES) cycles.
  - DONE is high during the cycle after the 16*(2+SETTLE_CYCLES)th rising edge following the START-sampling edge (the 48th edge for the default).
- Results hold after FIN until the next accepted START.
- START while BUSY or in FIN: ignored.
- ABORT while BUSY: IDLE at the next edge.
  - No DONE pulse; PASS stays 0; A..D = 0.
  - FAIL_CNT, FIRST_FAIL and SIGNATURE keep their partial values.
- ABORT together with START in IDLE: ABORT wins and the block stays in IDLE.
- Reset mid-run: immediate return to the reset state; no DONE.
- FAIL_CNT width covers 16, so it never saturates.

Decomposition:
- Shared package minority_pkg holds:
  - the state enumeration (IDLE, APPLY, SETTLE, SAMPLE, FIN);
  - NUM_VECTORS = 16;
  - the function minority_golden(vec, tie_value).
- No sub-module inside the controller. The settle timer and vector counter are local registers.
- The harness minority_bist_top instantiates minority_bist_ctrl together with the existing minority unit.

Test Plan:
- Correct minority unit, defaults, pulse START → A..D step 0000..1111, each held 3 cycles. DONE is high during the cycle after the 48th edge. PASS=1, FAIL_CNT=0, SIGNATURE=16'h0117.
- Z stuck at 0 → FAIL_CNT=5, FIRST_FAIL=0, SIGNATURE=16'h0000, PASS=0.
- Z stuck at 1 → FAIL_CNT=11, FIRST_FAIL=3, SIGNATURE=16'hFFFF, PASS=0.
- TIE_VALUE=1, SETTLE_CYCLES=0, unit with ties high → PASS=1, SIGNATURE=16'h177F. DONE is high during the cycle after the 32nd edge.
- ABORT asserted in the 20th BUSY cycle → IDLE next edge, no DONE, A..D=0, BUSY=0. A following START restarts from vec 0 with cleared results. START pulses mid-run cause no change.
- RST_N low mid-run → all outputs 0 immediately (asynchronous). START with ABORT=1 in IDLE → BUSY stays 0.
